// File: rtl/reaction_timer_pkg.sv
// Shared constants, state encoding and delay arithmetic for the reaction timer.
package reaction_timer_pkg;

  localparam int DELAY_BASE_DEFAULT = 1000;
  localparam int DELAY_STEP_DEFAULT = 100;
  localparam int TIMEOUT_DEFAULT    = 999;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WAIT = 3'd1;
  localparam state_t ST_GO   = 3'd2;
  localparam state_t ST_DONE = 3'd3;
  localparam state_t ST_FOUL = 3'd4;

  // Random wait in ticks; 13 bits covers base + 31 * step at the defaults.
  function automatic logic [12:0] calc_delay(input int base, input int step,
                                             input logic [4:0] r);
    return 13'(base + int'(r) * step);
  endfunction

endpackage

// File: rtl/reaction_timer.sv
// Reaction-time game controller: random wait, LED on, measure ms until stop.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int DELAY_BASE_MS = DELAY_BASE_DEFAULT,
  parameter int DELAY_STEP_MS = DELAY_STEP_DEFAULT,
  parameter int TIMEOUT_MS    = TIMEOUT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [4:0] rand_i,
  output logic       next_o,
  output logic       led_o,
  output logic [9:0] time_o,
  output logic       valid_o,
  output logic       foul_o,
  output logic       timeout_o,
  output state_t     state_o
);

  localparam logic [9:0] TIMEOUT_V = 10'(TIMEOUT_MS);

  state_t      state;
  logic [12:0] delay_cnt;
  logic [9:0]  react_cnt;
  logic [9:0]  react_next;
  logic        start_ok;

  assign start_ok   = start_i && ((state == ST_IDLE) || (state == ST_DONE) ||
                                  (state == ST_FOUL));
  // Gated by reset so the LFSR is never advanced while the block is held.
  assign next_o     = start_ok && rst_ni;
  assign led_o      = (state == ST_GO);
  assign react_next = react_cnt + 10'd1;
  assign state_o    = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      delay_cnt <= '0;
      react_cnt <= '0;
      time_o    <= '0;
      valid_o   <= 1'b0;
      foul_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FOUL: begin
          if (start_ok) begin
            delay_cnt <= calc_delay(DELAY_BASE_MS, DELAY_STEP_MS, rand_i);
            react_cnt <= '0;
            time_o    <= '0;
            valid_o   <= 1'b0;
            foul_o    <= 1'b0;
            timeout_o <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // An early press beats a final tick arriving in the same cycle.
          if (stop_i) begin
            foul_o <= 1'b1;
            state  <= ST_FOUL;
          end else if (tick_i) begin
            delay_cnt <= delay_cnt - 13'd1;
            if (delay_cnt <= 13'd1) begin
              react_cnt <= '0;
              state     <= ST_GO;
            end
          end
        end
        ST_GO: begin
          if (stop_i) begin
            time_o  <= react_cnt;
            valid_o <= 1'b1;
            state   <= ST_DONE;
          end else if (tick_i) begin
            if (react_next >= TIMEOUT_V) begin
              react_cnt <= TIMEOUT_V;
              time_o    <= TIMEOUT_V;
              valid_o   <= 1'b1;
              timeout_o <= 1'b1;
              state     <= ST_DONE;
            end else begin
              react_cnt <= react_next;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed self-checking bench for reaction_timer at default parameters.
module tb_reaction_timer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_GO   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_FOUL = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [4:0] rnd = '0;
  logic       next;
  logic       led;
  logic [9:0] time_ms;
  logic       valid;
  logic       foul;
  logic       timeout;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;
  logic led_seen = 1'b0;

  reaction_timer dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .tick_i   (tick),
    .start_i  (start),
    .stop_i   (stop),
    .rand_i   (rnd),
    .next_o   (next),
    .led_o    (led),
    .time_o   (time_ms),
    .valid_o  (valid),
    .foul_o   (foul),
    .timeout_o(timeout),
    .state_o  (state)
  );

  // Clock and led monitor
  always #5 clk = ~clk;
  always @(posedge clk) if (led) led_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs are driven at the falling edge and returned to idle one cycle later.
  task automatic cyc(input logic t, input logic s, input logic st);
    tick = t; stop = s; start = st;
    @(negedge clk);
    tick = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  // Start pulse with next_o observed combinationally before the edge.
  task automatic start_trial(input logic [4:0] r, input logic with_stop, input string tag);
    rnd = r; start = 1'b1; stop = with_stop;
    #1 chk({tag, "_next"}, next, 1);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk({tag, "_next_low"}, next, 0);
    chk({tag, "_state"}, state, S_WAIT);
    chk({tag, "_cleared"}, {time_ms, valid, foul, timeout}, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outputs", {next, led, time_ms, valid, foul, timeout}, 0);
    chk("rst_state", state, S_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b1, 1'b0);
    chk("idle_stop_ignored", {state, foul}, {S_IDLE, 1'b0});

    // rand=5 -> 1500-tick wait; start during WAIT ignored
    start_trial(5'd5, 1'b0, "t1");
    rnd = 5'd31;
    ticks(700);
    start = 1'b1;
    #1 chk("wait_start_no_next", next, 0);
    @(negedge clk);
    start = 1'b0;
    chk("wait_start_ignored", state, S_WAIT);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(799);
    chk("t1_led_before", led, 0);
    ticks(1);
    chk("t1_led_on", {led, state}, {1'b1, S_GO});

    // 237 ticks with gaps, then stop
    for (int i = 0; i < 237; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i % 50 == 0) cyc(1'b0, 1'b0, 1'b0);
    end
    chk("go_no_result_yet", valid, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t1_time", time_ms, 237);
    chk("t1_flags", {valid, led, foul, timeout, state}, {1'b1, 1'b0, 1'b0, 1'b0, S_DONE});
    cyc(1'b1, 1'b1, 1'b0);
    chk("done_held", {time_ms, valid, state}, {10'd237, 1'b1, S_DONE});

    // Foul at tick 400 of WAIT
    start_trial(5'd0, 1'b0, "t2");
    led_seen = 1'b0;
    ticks(399);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t2_foul", {foul, valid, led, state}, {1'b1, 1'b0, 1'b0, S_FOUL});
    chk("t2_led_never", led_seen, 0);

    // Stop beats the final WAIT tick
    start_trial(5'd0, 1'b1, "t3");
    ticks(999);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t3_stop_wins", {foul, led, state}, {1'b1, 1'b0, S_FOUL});

    // Timeout after 999 ticks in GO
    start_trial(5'd0, 1'b1, "t4");
    ticks(1000);
    chk("t4_go", state, S_GO);
    ticks(998);
    chk("t4_not_yet", {state, valid}, {S_GO, 1'b0});
    ticks(1);
    chk("t4_timeout", {time_ms, timeout, valid, led, state},
        {10'd999, 1'b1, 1'b1, 1'b0, S_DONE});

    // Stop together with tick at react_cnt=50
    start_trial(5'd0, 1'b0, "t5");
    ticks(1000);
    ticks(50);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t5_time", {time_ms, valid, timeout}, {10'd50, 1'b1, 1'b0});

    // Asynchronous reset mid-GO, then a clean trial with rand=1
    start_trial(5'd0, 1'b0, "t6");
    ticks(1010);
    chk("t6_in_go", led, 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_rst", {next, led, time_ms, valid, foul, timeout, state}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_trial(5'd1, 1'b0, "t7");
    ticks(1099);
    chk("t7_led_before", led, 0);
    ticks(1);
    chk("t7_led_on", led, 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t7_time", {time_ms, valid, state}, {10'd0, 1'b1, S_DONE});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
